// File: rtl/pb1_switch_pio.sv
// pb1_switch_pio: WIDTH-bit Avalon-MM slave input PIO for board switches and
// push-buttons. Each pin is synchronised, debounced, edge-captured and can
// raise a maskable level interrupt.
//
// Ports:
//   clk        system clock, everything on the rising edge
//   reset_n    synchronous active-low reset
//   address    register select: 0 data, 1 reserved, 2 irq_mask, 3 edge_capture
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data (only [WIDTH-1:0] is used)
//   in_port    asynchronous switch/button pins
//   readdata   registered read data, one cycle latency, upper bits zero
//   irq        registered level interrupt request
module pb1_switch_pio #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out_s;
  logic [WIDTH-1:0] filtered_r;
  logic [WIDTH-1:0] filtered_next_s;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] edge_capture_r;
  logic [WIDTH-1:0] mask_next_s;
  logic [WIDTH-1:0] clear_s;
  logic [WIDTH-1:0] capture_next_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] new_edge_s;
  logic             wr_s;
  logic [31:0]      read_mux_s;
  logic             unused_wdata_s;

  // Bits above WIDTH of writedata have no destination.
  assign unused_wdata_s = ^{1'b0, writedata};

  assign sync_out_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the raw pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_r[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // Without a filter the synchronised level is accepted every cycle.
      always_comb begin
        filtered_next_s = sync_out_s;
      end
    end else begin : g_filter
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_r      [WIDTH];
      logic [CNT_W-1:0] cnt_next_s [WIDTH];

      // Per-bit filter: a new level is accepted only after it has differed
      // from the filtered value for DEBOUNCE_CYCLES consecutive cycles.
      always_comb begin
        filtered_next_s = filtered_r;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_next_s[i] = {CNT_W{1'b0}};
          if (sync_out_s[i] == filtered_r[i]) begin
            cnt_next_s[i] = {CNT_W{1'b0}};
          end else if (cnt_r[i] == CNT_LAST) begin
            filtered_next_s[i] = sync_out_s[i];
            cnt_next_s[i]      = {CNT_W{1'b0}};
          end else begin
            cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
          end
        end
      end

      // Debounce counters; reset discards any debounce in progress.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
          end
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= cnt_next_s[i];
          end
        end
      end
    end
  endgenerate

  // Edge detection on the filtered value, selected by EDGE_TYPE.
  always_comb begin
    rise_s = filtered_next_s & ~filtered_r;
    fall_s = ~filtered_next_s & filtered_r;
    case (EDGE_TYPE)
      32'sd0:  new_edge_s = rise_s;
      32'sd1:  new_edge_s = fall_s;
      default: new_edge_s = rise_s | fall_s;
    endcase
  end

  // Register writes and read mux. A new edge beats a same-cycle W1C clear,
  // and the read mux always shows pre-write contents.
  always_comb begin
    wr_s = chipselect & ~write_n;
    if (wr_s && (address == 2'd2)) begin
      mask_next_s = writedata[WIDTH-1:0];
    end else begin
      mask_next_s = irq_mask_r;
    end
    if (wr_s && (address == 2'd3)) begin
      clear_s = writedata[WIDTH-1:0];
    end else begin
      clear_s = {WIDTH{1'b0}};
    end
    capture_next_s = (edge_capture_r & ~clear_s) | new_edge_s;

    read_mux_s = 32'd0;
    case (address)
      2'd0:    read_mux_s[WIDTH-1:0] = filtered_r;
      2'd1:    read_mux_s = 32'd0;
      2'd2:    read_mux_s[WIDTH-1:0] = irq_mask_r;
      2'd3:    read_mux_s[WIDTH-1:0] = edge_capture_r;
      default: read_mux_s = 32'd0;
    endcase
  end

  // Architectural state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filtered_r     <= {WIDTH{1'b0}};
      irq_mask_r     <= {WIDTH{1'b0}};
      edge_capture_r <= {WIDTH{1'b0}};
      readdata       <= 32'd0;
      irq            <= 1'b0;
    end else begin
      filtered_r     <= filtered_next_s;
      irq_mask_r     <= mask_next_s;
      edge_capture_r <= capture_next_s;
      readdata       <= read_mux_s;
      irq            <= |(capture_next_s & mask_next_s);
    end
  end

endmodule
